seg7_mux_driver: RTL and testbench
==================================

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (1..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, giving clock cycles per digit slot (>=1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts segments and digit_en.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data, input, 4*NUM_DIGITS; nibble k is the value for digit k, with digit 0 least significant.
REQ-007 SHALL have port dp_in, input, NUM_DIGITS; bit k is the decimal point for digit k.
REQ-008 SHALL have port load, input, 1; when high, data and dp_in are captured this edge.
REQ-009 SHALL have port hex_mode, input, 1; 1 = show codes 10-15 as A-F, 0 = blank them.
REQ-010 SHALL have port blank_lz, input, 1; 1 = suppress leading zeros.
REQ-011 SHALL have port segments, output, 8; bit7 = dp, bits6:0 = a..g, registered.
REQ-012 SHALL have port digit_en, output, NUM_DIGITS; one-hot digit enable, registered.
REQ-013 SHALL have port frame_done, output, 1; one-cycle pulse when the digit index wraps.

Function
REQ-014 SHALL run refresh counter 0..REFRESH_DIV-1; at terminal count it reloads 0 and the digit index advances.
REQ-015 SHALL advance the digit index 0..NUM_DIGITS-1, wrapping NUM_DIGITS-1 -> 0; frame_done SHALL be 1 for the cycle after the wrap edge.
REQ-016 SHALL write the load capture into a pending register and set pending_valid.
REQ-017 SHALL, on each wrap edge with pending_valid=1, copy pending to the active register and clear pending_valid, so no frame shows mixed data.
REQ-018 SHALL, when load and a wrap coincide, write the new data directly to active and clear pending_valid.
REQ-019 SHALL, on a second load before a wrap, overwrite pending with the newer data.
REQ-020 SHALL decode 0-9 (a..g) as 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1110011.
REQ-021 SHALL decode A-F with hex_mode=1 as 1110111, 0011111, 1001110, 0111101, 1001111, 1000111; with hex_mode=0 codes 10-15 SHALL give 0000000.
REQ-022 SHALL, with blank_lz=1, blank a..g of digit k when active nibbles k..NUM_DIGITS-1 are all zero and k>0; digit 0 SHALL never be suppressed.
REQ-023 SHALL never suppress the dp bit, which is active dp bit k.
REQ-024 SHALL register segments and digit_en together; they reflect the index held before the edge, giving 1-cycle latency.
REQ-025 SHALL apply hex_mode and blank_lz combinationally to the current active data, without waiting for a frame boundary.
REQ-026 SHALL, with REFRESH_DIV=1, advance the index every cycle; with NUM_DIGITS=1, pulse frame_done at every terminal count.
REQ-027 SHALL apply ACTIVE_LOW as a final inversion of segments and digit_en only.

Reset
REQ-028 SHALL, with reset high, clear the refresh counter, digit index, active, pending and pending_valid to 0.
REQ-029 SHALL, with reset high, drive segments and digit_en inactive (all 0, or all 1 if ACTIVE_LOW) and frame_done 0.
REQ-030 SHALL, on reset mid-frame, discard pending data, and reset SHALL take priority over load.
REQ-031 SHALL, on the first edge after reset deassertion, drive digit_en = digit 0 with active data 0 decoded (1111110).

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0)
REQ-032 SHALL cover: reset, load data=16'h1234 then wait for a wrap -> digit_en walks 0001, 0010, 0100, 1000, 4 cycles each; segments are 0110011, 1111001, 1101101, 0110000 for digits 0..3; frame_done pulses every 16 cycles.
REQ-033 SHALL cover: data=16'h00A5, hex_mode=0, blank_lz=1 -> digit1 0000000, digits 2 and 3 blanked, digit0 1011011; with hex_mode=1, digit1 1110111 and digits 2 and 3 still blanked.
REQ-034 SHALL cover: data=16'h0000, blank_lz=1, dp_in=4'b0100 -> digit0 1111110, digits 1 and 3 segments 0, digit2 segments 10000000.
REQ-035 SHALL cover: load 16'h1111 mid-frame, then 16'h2222 before the wrap -> the current frame is unchanged; the next frame shows all 1101101.
REQ-036 SHALL cover: load asserted on the wrap edge -> new data is shown from digit 0 of the next frame, and pending_valid is 0 afterwards.
REQ-037 SHALL cover: reset pulsed on digit 2 with pending loaded -> outputs inactive during reset; after release digit 0 shows 1111110 and the pending data is never displayed.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed seven-segment display driver.
// Walks a one-hot digit enable across NUM_DIGITS digits, spending REFRESH_DIV
// cycles on each. Newly loaded data waits in a pending register and is only
// promoted to the displayed (active) register when the digit index wraps, so a
// frame never shows a mix of old and new values.
module seg7_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_INV  = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_INV   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]         refreshCnt_q, refreshCnt_d;
  logic [IW-1:0]         digitIdx_q, digitIdx_d;
  logic [DW-1:0]         activeData_q, activeData_d;
  logic [NUM_DIGITS-1:0] activeDp_q, activeDp_d;
  logic [DW-1:0]         pendData_q, pendData_d;
  logic [NUM_DIGITS-1:0] pendDp_q, pendDp_d;
  logic                  pendValid_q, pendValid_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digitEn_q, digitEn_d;
  logic                  frameDone_q, frameDone_d;

  logic                  terminal;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] leadZero;
  logic                  zeroRun;
  logic [3:0]            curNibble;
  logic                  curDp;
  logic                  curLz;
  logic [6:0]            glyph;

  // Refresh counter and digit index: the index steps on each terminal count and wraps after the last digit.
  always_comb begin
    terminal     = (refreshCnt_q == CNT_LAST);
    wrap         = terminal && (digitIdx_q == IDX_LAST);
    refreshCnt_d = terminal ? '0 : refreshCnt_q + CW'(1);
    digitIdx_d   = digitIdx_q;
    if (terminal) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IW'(1);
    end
  end

  // Double buffering: loads land in pending, and pending becomes active only at a frame wrap.
  always_comb begin
    activeData_d = activeData_q;
    activeDp_d   = activeDp_q;
    pendData_d   = pendData_q;
    pendDp_d     = pendDp_q;
    pendValid_d  = pendValid_q;
    if (load && wrap) begin
      activeData_d = data;
      activeDp_d   = dp_in;
      pendValid_d  = 1'b0;
    end else begin
      if (wrap && pendValid_q) begin
        activeData_d = pendData_q;
        activeDp_d   = pendDp_q;
        pendValid_d  = 1'b0;
      end
      if (load) begin
        pendData_d  = data;
        pendDp_d    = dp_in;
        pendValid_d = 1'b1;
      end
    end
  end

  // Leading-zero map (digit k is a leading zero if it and every higher nibble are zero) and current-digit select.
  always_comb begin
    leadZero  = '0;
    zeroRun   = 1'b1;
    curNibble = 4'd0;
    curDp     = 1'b0;
    curLz     = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeroRun     = zeroRun && (activeData_q[4*k +: 4] == 4'd0);
      leadZero[k] = zeroRun && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIdx_q == IW'(k)) begin
        curNibble = activeData_q[4*k +: 4];
        curDp     = activeDp_q[k];
        curLz     = leadZero[k];
      end
    end
  end

  // Seven-segment glyph lookup, bit 6 = a down to bit 0 = g; hex letters appear only in hex mode.
  always_comb begin
    glyph = 7'b0000000;
    case (curNibble)
      4'h0:    glyph = 7'b1111110;
      4'h1:    glyph = 7'b0110000;
      4'h2:    glyph = 7'b1101101;
      4'h3:    glyph = 7'b1111001;
      4'h4:    glyph = 7'b0110011;
      4'h5:    glyph = 7'b1011011;
      4'h6:    glyph = 7'b1011111;
      4'h7:    glyph = 7'b1110000;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1110011;
      4'hA:    glyph = hex_mode ? 7'b1110111 : 7'b0000000;
      4'hB:    glyph = hex_mode ? 7'b0011111 : 7'b0000000;
      4'hC:    glyph = hex_mode ? 7'b1001110 : 7'b0000000;
      4'hD:    glyph = hex_mode ? 7'b0111101 : 7'b0000000;
      4'hE:    glyph = hex_mode ? 7'b1001111 : 7'b0000000;
      4'hF:    glyph = hex_mode ? 7'b1000111 : 7'b0000000;
      default: glyph = 7'b0000000;
    endcase
  end

  // Next output word for the digit selected before this edge; the decimal point is never blanked.
  always_comb begin
    seg_d       = {curDp, (blank_lz && curLz) ? 7'b0000000 : glyph};
    digitEn_d   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digitEn_d[k] = (digitIdx_q == IW'(k));
    end
    frameDone_d = wrap;
  end

  // State and output registers with synchronous reset that also discards any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= '0;
      activeData_q <= '0;
      activeDp_q   <= '0;
      pendData_q   <= '0;
      pendDp_q     <= '0;
      pendValid_q  <= 1'b0;
      seg_q        <= '0;
      digitEn_q    <= '0;
      frameDone_q  <= 1'b0;
    end else begin
      refreshCnt_q <= refreshCnt_d;
      digitIdx_q   <= digitIdx_d;
      activeData_q <= activeData_d;
      activeDp_q   <= activeDp_d;
      pendData_q   <= pendData_d;
      pendDp_q     <= pendDp_d;
      pendValid_q  <= pendValid_d;
      seg_q        <= seg_d;
      digitEn_q    <= digitEn_d;
      frameDone_q  <= frameDone_d;
    end
  end

  assign segments   = seg_q ^ SEG_INV;
  assign digit_en   = digitEn_q ^ EN_INV;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver with 4 digits and 4 cycles per digit slot.
// Each scenario task drives directed vectors and checks against hand-computed patterns.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic [7:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;

  seg7_mux_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .dp_in     (dp_in),
    .load      (load),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .segments  (segments),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_done is seen, bounded at 40 cycles.
  task automatic waitFrame(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    compared++;
    if (frame_done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s: frame_done=%b required=1 within 40 cycles", name, frame_done);
    end
  endtask

  // Reset holds outputs inactive and overrides load; first edge after release shows digit 0 as "0".
  task automatic test_reset();
    reset = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF;
    hex_mode = 1'b0; blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared += 3;
      if (segments !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_seg[%0d]: got %b want %b", i, segments, 8'h00); end
      if (digit_en !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_en[%0d]: got %b want 0000", i, digit_en); end
      if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fd[%0d]: got %b want 0", i, frame_done); end
    end
    reset = 1'b0; load = 1'b0; data = 16'h0000; dp_in = 4'h0;
    tick();
    compared += 3;
    if (digit_en !== 4'b0001) begin mismatched++; $display("[TB] FAIL first_en: got %b want 0001", digit_en); end
    if (segments !== 8'b0111_1110) begin mismatched++; $display("[TB] FAIL first_seg: got %b want 01111110", segments); end
    if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL first_fd: got %b want 0", frame_done); end
  endtask

  // 0x1234 walks digits 0..3, four cycles each, frame_done every 16 cycles.
  task automatic test_walk();
    logic [7:0] exp [4] = '{8'b0011_0011, 8'b0111_1001, 8'b0110_1101, 8'b0011_0000};
    logic [3:0] expEn;
    data = 16'h1234; dp_in = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    waitFrame("walk_sync");
    for (int i = 0; i < 16; i++) begin
      tick();
      expEn = 4'b0001 << (i / 4);
      compared += 3;
      if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL walk_en[%0d]: got %b want %b", i, digit_en, expEn); end
      if (segments !== exp[i/4]) begin mismatched++; $display("[TB] FAIL walk_seg[%0d]: got %b want %b", i, segments, exp[i/4]); end
      if (frame_done !== (i == 15)) begin mismatched++; $display("[TB] FAIL walk_fd[%0d]: got %b want %b", i, frame_done, (i == 15)); end
    end
  endtask

  // 0x00A5 with leading-zero blanking, first with hex letters off, then on.
  task automatic test_hex_blank();
    logic [7:0] exp [2][4] = '{'{8'b0101_1011, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000},
                                '{8'b0101_1011, 8'b0111_0111, 8'b0000_0000, 8'b0000_0000}};
    logic [3:0] expEn;
    data = 16'h00A5; dp_in = 4'h0; hex_mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    waitFrame("hex_sync");
    for (int f = 0; f < 2; f++) begin
      hex_mode = (f == 1);
      for (int i = 0; i < 16; i++) begin
        tick();
        expEn = 4'b0001 << (i / 4);
        compared += 3;
        if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL hex_en[%0d][%0d]: got %b want %b", f, i, digit_en, expEn); end
        if (segments !== exp[f][i/4]) begin mismatched++; $display("[TB] FAIL hex_seg[%0d][%0d]: got %b want %b", f, i, segments, exp[f][i/4]); end
        if (frame_done !== (i == 15)) begin mismatched++; $display("[TB] FAIL hex_fd[%0d][%0d]: got %b want %b", f, i, frame_done, (i == 15)); end
      end
    end
  endtask

  // All-zero data with blanking: digit 0 stays "0", a blanked digit still shows its decimal point.
  task automatic test_dp_zero();
    logic [7:0] exp [4] = '{8'b0111_1110, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000};
    logic [3:0] expEn;
    hex_mode = 1'b0; blank_lz = 1'b1; data = 16'h0000; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    waitFrame("dp_sync");
    for (int i = 0; i < 16; i++) begin
      tick();
      expEn = 4'b0001 << (i / 4);
      compared += 3;
      if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL dp_en[%0d]: got %b want %b", i, digit_en, expEn); end
      if (segments !== exp[i/4]) begin mismatched++; $display("[TB] FAIL dp_seg[%0d]: got %b want %b", i, segments, exp[i/4]); end
      if (frame_done !== (i == 15)) begin mismatched++; $display("[TB] FAIL dp_fd[%0d]: got %b want %b", i, frame_done, (i == 15)); end
    end
  endtask

  // Two loads inside one frame: the frame is untouched, the next frame shows only the newer value.
  task automatic test_double_load();
    logic [7:0] exp [2][4] = '{'{8'b0111_1110, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000},
                                '{8'b0110_1101, 8'b0110_1101, 8'b0110_1101, 8'b0110_1101}};
    logic [3:0] expEn;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        load  = (f == 0) && (i == 3 || i == 9);
        data  = (i == 3) ? 16'h1111 : 16'h2222;
        dp_in = 4'h0;
        tick();
        load = 1'b0;
        expEn = 4'b0001 << (i / 4);
        compared += 3;
        if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL dbl_en[%0d][%0d]: got %b want %b", f, i, digit_en, expEn); end
        if (segments !== exp[f][i/4]) begin mismatched++; $display("[TB] FAIL dbl_seg[%0d][%0d]: got %b want %b", f, i, segments, exp[f][i/4]); end
        if (frame_done !== (i == 15)) begin mismatched++; $display("[TB] FAIL dbl_fd[%0d][%0d]: got %b want %b", f, i, frame_done, (i == 15)); end
      end
    end
  endtask

  // A stale pending load followed by a load on the wrap edge: the wrap-edge data wins for every later frame.
  task automatic test_load_on_wrap();
    logic [7:0] exp [3][4] = '{'{8'b0110_1101, 8'b0110_1101, 8'b0110_1101, 8'b0110_1101},
                                '{8'b0101_1011, 8'b0101_1111, 8'b0111_0000, 8'b0111_1111},
                                '{8'b0101_1011, 8'b0101_1111, 8'b0111_0000, 8'b0111_1111}};
    logic [3:0] expEn;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        load  = (f == 0) && (i == 5 || i == 15);
        data  = (i == 5) ? 16'h9999 : 16'h8765;
        dp_in = 4'h0;
        tick();
        load = 1'b0;
        expEn = 4'b0001 << (i / 4);
        compared += 3;
        if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL wrap_en[%0d][%0d]: got %b want %b", f, i, digit_en, expEn); end
        if (segments !== exp[f][i/4]) begin mismatched++; $display("[TB] FAIL wrap_seg[%0d][%0d]: got %b want %b", f, i, segments, exp[f][i/4]); end
        if (frame_done !== (i == 15)) begin mismatched++; $display("[TB] FAIL wrap_fd[%0d][%0d]: got %b want %b", f, i, frame_done, (i == 15)); end
      end
    end
  endtask

  // Reset on digit 2 with a load pending: outputs go inactive, and afterwards only zeros are ever shown.
  task automatic test_reset_mid();
    logic [3:0] expEn;
    blank_lz = 1'b0; hex_mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load = (i == 1); data = 16'h4444; dp_in = 4'h0;
      tick();
      load = 1'b0;
    end
    compared += 2;
    if (digit_en !== 4'b0100) begin mismatched++; $display("[TB] FAIL mid_pre_en: got %b want 0100", digit_en); end
    if (segments !== 8'b0111_0000) begin mismatched++; $display("[TB] FAIL mid_pre_seg: got %b want 01110000", segments); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      compared += 3;
      if (segments !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_rst_seg[%0d]: got %b want 00000000", i, segments); end
      if (digit_en !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_rst_en[%0d]: got %b want 0000", i, digit_en); end
      if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_fd[%0d]: got %b want 0", i, frame_done); end
    end
    reset = 1'b0;
    tick();
    compared += 2;
    if (digit_en !== 4'b0001) begin mismatched++; $display("[TB] FAIL mid_first_en: got %b want 0001", digit_en); end
    if (segments !== 8'b0111_1110) begin mismatched++; $display("[TB] FAIL mid_first_seg: got %b want 01111110", segments); end
    for (int i = 0; i < 31; i++) begin
      tick();
      expEn = 4'b0001 << (((i + 1) / 4) % 4);
      compared += 3;
      if (digit_en !== expEn) begin mismatched++; $display("[TB] FAIL mid_en[%0d]: got %b want %b", i, digit_en, expEn); end
      if (segments !== 8'b0111_1110) begin mismatched++; $display("[TB] FAIL mid_seg[%0d]: got %b want 01111110", i, segments); end
      if (frame_done !== (i == 14 || i == 30)) begin mismatched++; $display("[TB] FAIL mid_fd[%0d]: got %b want %b", i, frame_done, (i == 14 || i == 30)); end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_walk();
    test_hex_blank();
    test_dp_zero();
    test_double_load();
    test_load_on_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time limit in case the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
